// File: rtl/serv_pkg.sv
// Shared SERV definitions: datapath width, serializer FSM states and 6-bit ALU instruction codes.
package serv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INST_W = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef logic [INST_W-1:0] inst_t;

    localparam inst_t INST_NOP = 6'b000000;
    localparam inst_t INST_ADD = 6'b100101;
    localparam inst_t INST_SUB = 6'b001010;
    localparam inst_t INST_XOR = 6'b000100;
    localparam inst_t INST_AND = 6'b000010;
    localparam inst_t INST_OR  = 6'b000001;
    localparam inst_t INST_LT  = 6'b010000;
    localparam inst_t INST_EQ  = 6'b001000;

endpackage

// File: rtl/operand_tx_if.sv
// Operand serializer bus: parallel operand handshake in, serial bit pair and status out.
interface operand_tx_if
    import serv_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] i_op1;
    logic [WIDTH-1:0] i_op2;
    inst_t            i_inst;
    logic             i_valid;
    logic             o_ready;
    logic             o_A;
    logic             o_B;
    inst_t            o_inst;
    logic             i_advance;
    logic             o_busy;
    logic             o_done;
    logic [IDX_W-1:0] o_bit_idx;

    modport master (
        output i_op1, i_op2, i_inst, i_valid, i_advance,
        input  o_ready, o_A, o_B, o_inst, o_busy, o_done, o_bit_idx
    );

    modport slave (
        input  i_op1, i_op2, i_inst, i_valid, i_advance,
        output o_ready, o_A, o_B, o_inst, o_busy, o_done, o_bit_idx
    );

endinterface

// File: rtl/operand_shreg.sv
// Operand pair register: parallel load, or zero-filling right shift; bit 0 of each is the serial output.
module operand_shreg
    import serv_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic             o_a,
    output logic             o_b
);

    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;

    // Load wins over shift so a queued pair can replace the last beat in the same edge.
    always_comb begin
        op1_d = op1_q;
        op2_d = op2_q;
        if (i_load) begin
            op1_d = i_op1;
            op2_d = i_op2;
        end else if (i_shift) begin
            op1_d = {1'b0, op1_q[WIDTH-1:1]};
            op2_d = {1'b0, op2_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op1_q <= '0;
            op2_q <= '0;
        end else begin
            op1_q <= op1_d;
            op2_q <= op2_d;
        end
    end

    assign o_a = op1_q[0];
    assign o_b = op2_q[0];

endmodule

// File: rtl/operand_tx.sv
// Serializes an operand pair LSB first, one beat per i_advance.
// Define OPERAND_TX_SKID_EN for a one-entry holding buffer giving back-to-back transfers.
module operand_tx
    import serv_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic        clk,
    input  logic        reset,
    operand_tx_if.slave bus
);

    localparam int unsigned      IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    inst_t            inst_q, inst_d;

    logic             accept_c;
    logic             last_c;
    logic             load_c;
    logic             shift_c;
    logic [WIDTH-1:0] ld_op1_c;
    logic [WIDTH-1:0] ld_op2_c;

`ifdef OPERAND_TX_SKID_EN
    logic             skid_full_q, skid_full_d;
    logic [WIDTH-1:0] skid_op1_q, skid_op1_d;
    logic [WIDTH-1:0] skid_op2_q, skid_op2_d;
    inst_t            skid_inst_q, skid_inst_d;
`endif

    assign accept_c = bus.i_valid && ready_q;
    assign last_c   = (state_q == SHIFT) && bus.i_advance && (idx_q == LAST_IDX);

    // Next-state, beat counter, shift-register control and holding buffer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        inst_d   = inst_q;
        load_c   = 1'b0;
        shift_c  = 1'b0;
        ld_op1_c = bus.i_op1;
        ld_op2_c = bus.i_op2;
`ifdef OPERAND_TX_SKID_EN
        skid_full_d = skid_full_q;
        skid_op1_d  = skid_op1_q;
        skid_op2_d  = skid_op2_q;
        skid_inst_d = skid_inst_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    load_c  = 1'b1;
                    state_d = SHIFT;
                    idx_d   = '0;
                    inst_d  = bus.i_inst;
                end
            end
            SHIFT: begin
                if (bus.i_advance) begin
                    shift_c = 1'b1;
                    idx_d   = last_c ? '0 : idx_q + IDX_W'(1);
                end
                if (last_c) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`ifdef OPERAND_TX_SKID_EN
                // On the last beat a waiting pair (stored first, else arriving now) starts with no bubble.
                if (last_c && skid_full_q) begin
                    load_c      = 1'b1;
                    state_d     = SHIFT;
                    ld_op1_c    = skid_op1_q;
                    ld_op2_c    = skid_op2_q;
                    inst_d      = skid_inst_q;
                    skid_full_d = 1'b0;
                end else if (last_c && accept_c) begin
                    load_c  = 1'b1;
                    state_d = SHIFT;
                    inst_d  = bus.i_inst;
                end else if (accept_c) begin
                    skid_full_d = 1'b1;
                    skid_op1_d  = bus.i_op1;
                    skid_op2_d  = bus.i_op2;
                    skid_inst_d = bus.i_inst;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
`ifdef OPERAND_TX_SKID_EN
        ready_d = !skid_full_d;
`else
        ready_d = (state_d == IDLE);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            inst_q  <= inst_d;
        end
    end

`ifdef OPERAND_TX_SKID_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_full_q <= 1'b0;
            skid_op1_q  <= '0;
            skid_op2_q  <= '0;
            skid_inst_q <= '0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_op1_q  <= skid_op1_d;
            skid_op2_q  <= skid_op2_d;
            skid_inst_q <= skid_inst_d;
        end
    end
`endif

    operand_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (load_c),
        .i_shift (shift_c),
        .i_op1   (ld_op1_c),
        .i_op2   (ld_op2_c),
        .o_a     (bus.o_A),
        .o_b     (bus.o_B)
    );

    assign bus.o_ready   = ready_q;
    assign bus.o_busy    = (state_q == SHIFT);
    assign bus.o_done    = done_q;
    assign bus.o_inst    = inst_q;
    assign bus.o_bit_idx = idx_q;

endmodule
